event_packer: RTL and testbench

EVENT_PACKER -- requirements
Module: event_packer

---
 rtl/event_packer_if.sv | 34 +++
 rtl/event_packer.sv | 82 ++++++++
 tb/tb_event_packer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/event_packer_if.sv
// Event packer handshake bundle: arbiter-side capture inputs and downstream event stream.
// The master drives the capture inputs and ready_i; the slave (the packer) drives the outputs.
interface event_packer_if #(
    parameter int unsigned X_W    = 4,
    parameter int unsigned Y_W    = 4,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
) ();
    localparam int unsigned EW = TS_W + Y_W + X_W + 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              enable_i;
    logic              active_i;
    logic [X_W-1:0]    x_add_i;
    logic [Y_W-1:0]    y_add_i;
    logic              pol_i;
    logic              ready_i;
    logic              valid_o;
    logic [EW-1:0]     event_o;
    logic [CW-1:0]     count_o;
    logic              overflow_o;
    logic [DROP_W-1:0] drop_cnt_o;

    modport master (
        output enable_i, active_i, x_add_i, y_add_i, pol_i, ready_i,
        input  valid_o, event_o, count_o, overflow_o, drop_cnt_o
    );

    modport slave (
        input  enable_i, active_i, x_add_i, y_add_i, pol_i, ready_i,
        output valid_o, event_o, count_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/event_packer.sv
// Timestamps granted pixel events and buffers them in a small FIFO; events arriving
// while the FIFO is full and not draining are dropped and counted.
module event_packer #(
    parameter int unsigned X_W    = 4,
    parameter int unsigned Y_W    = 4,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
) (
    input logic           clk_i,
    input logic           reset_i,
    event_packer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = TS_W + Y_W + X_W + 1;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [TS_W-1:0]   ts_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_q;

    logic push, pop, full, valid, accept, drop;

    assign push   = bus.active_i & bus.enable_i;
    assign valid  = (count_q != '0);
    assign pop    = valid & bus.ready_i;
    assign full   = (count_q == CW'(DEPTH));
    // A full FIFO still accepts a push when a slot frees up in the same cycle.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q    <= ts_q + TS_W'(1);
            count_q <= count_d;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + DROP_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {ts_q, bus.y_add_i, bus.x_add_i, bus.pol_i};
        end
    end

    assign bus.valid_o    = valid;
    assign bus.event_o    = mem_q[rd_ptr_q];
    assign bus.count_o    = count_q;
    assign bus.overflow_o = overflow_q;
    assign bus.drop_cnt_o = drop_q;
endmodule

// File: tb/tb_event_packer.sv
// Self-checking bench for event_packer: queue-based reference model, a vector table,
// and directed sequences for reset, overflow saturation and timestamp wrap.
module tb_event_packer;
    localparam int unsigned X_W    = 4;
    localparam int unsigned Y_W    = 4;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned EW     = TS_W + Y_W + X_W + 1;

    logic clk;
    logic reset;

    event_packer_if #(
        .X_W(X_W), .Y_W(Y_W), .TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) bus ();

    event_packer #(
        .X_W(X_W), .Y_W(Y_W), .TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ordered list of stored events plus drop bookkeeping.
    logic [EW-1:0]   mq [$];
    logic [TS_W-1:0] m_ts;
    bit              m_ovf;
    int              m_drop;

    typedef struct {
        bit act;
        bit en;
        bit rdy;
        int exp_count;
        bit exp_valid;
        bit exp_ovf;
        int exp_drop;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(bit a, bit e, bit r, int c, bit v, bit o, int d);
        vec_t t;
        t.act = a; t.en = e; t.rdy = r;
        t.exp_count = c; t.exp_valid = v; t.exp_ovf = o; t.exp_drop = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 64'(bus.count_o), 64'(mq.size()));
        chk({tag, "_valid"}, 64'(bus.valid_o), 64'(mq.size() != 0));
        chk({tag, "_ovf"}, 64'(bus.overflow_o), 64'(m_ovf));
        chk({tag, "_drop"}, 64'(bus.drop_cnt_o), 64'(m_drop));
        if (mq.size() != 0) chk({tag, "_event"}, 64'(bus.event_o), 64'(mq[0]));
    endtask

    task automatic set_in(input bit a, input bit e, input bit r);
        bus.active_i = a;
        bus.enable_i = e;
        bus.ready_i  = r;
        bus.x_add_i  = X_W'($urandom);
        bus.y_add_i  = Y_W'($urandom);
        bus.pol_i    = 1'($urandom);
    endtask

    // Called at a falling edge with inputs set; advances one clock and checks.
    task automatic step();
        bit full, pop, push;
        full = (mq.size() == DEPTH);
        pop  = (mq.size() != 0) && bus.ready_i;
        push = bus.active_i && bus.enable_i;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (!full || pop) begin
                mq.push_back({m_ts, bus.y_add_i, bus.x_add_i, bus.pol_i});
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        m_ts = m_ts + 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_state("step");
    endtask

    // Asserted at a falling edge: outputs must clear without waiting for a clock.
    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_ovf", 64'(bus.overflow_o), 64'd0);
        chk("rst_drop", 64'(bus.drop_cnt_o), 64'd0);
        mq.delete();
        m_ts   = '0;
        m_ovf  = 1'b0;
        m_drop = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [EW-1:0] exp38;
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Single event at ts=10 with known fields.
        do_reset();
        repeat (10) step();
        set_in(1'b1, 1'b1, 1'b1);
        bus.x_add_i = 4'd3;
        bus.y_add_i = 4'd5;
        bus.pol_i   = 1'b1;
        step();
        exp38 = {16'd10, 4'd5, 4'd3, 1'b1};
        chk("r38_valid", 64'(bus.valid_o), 64'd1);
        chk("r38_event", 64'(bus.event_o), 64'(exp38));
        set_in(1'b0, 1'b1, 1'b1);
        step();
        chk("r38_count", 64'(bus.count_o), 64'd0);

        // Vector table: enable gating, push/pop mixes, fill, drop, full push+pop.
        tbl[0] = mk(1, 1, 0, 1, 1, 0, 0);
        tbl[1] = mk(1, 0, 0, 1, 1, 0, 0);
        tbl[2] = mk(1, 1, 0, 2, 1, 0, 0);
        tbl[3] = mk(0, 1, 1, 1, 1, 0, 0);
        tbl[4] = mk(1, 1, 1, 1, 1, 0, 0);
        tbl[5] = mk(0, 0, 1, 0, 0, 0, 0);
        tbl[6] = mk(0, 1, 1, 0, 0, 0, 0);
        for (int i = 7; i < 15; i++) tbl[i] = mk(1, 1, 0, i - 6, 1, 0, 0);
        tbl[15] = mk(1, 1, 0, 8, 1, 1, 1);
        tbl[16] = mk(1, 1, 1, 8, 1, 1, 1);
        tbl[17] = mk(0, 1, 1, 7, 1, 1, 1);
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].act, tbl[i].en, tbl[i].rdy);
            step();
            chk($sformatf("tbl%0d_count", i), 64'(bus.count_o), 64'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_valid", i), 64'(bus.valid_o), 64'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_ovf", i), 64'(bus.overflow_o), 64'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_drop", i), 64'(bus.drop_cnt_o), 64'(tbl[i].exp_drop));
        end
        set_in(1'b0, 1'b0, 1'b1);
        repeat (8) step();
        chk("drain_count", 64'(bus.count_o), 64'd0);

        // Drop counter saturation.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0);
        repeat (300) step();
        chk("sat_drop", 64'(bus.drop_cnt_o), 64'd255);
        chk("sat_ovf", 64'(bus.overflow_o), 64'd1);
        chk("sat_count", 64'(bus.count_o), 64'd8);

        // Mid-operation reset with stored entries, then a fresh push.
        do_reset();
        repeat (4) begin
            set_in(1'b1, 1'b1, 1'b0);
            step();
        end
        chk("pre_rst_count", 64'(bus.count_o), 64'd4);
        do_reset();
        set_in(1'b1, 1'b1, 1'b0);
        step();
        chk("post_rst_ts", 64'(bus.event_o[EW-1 -: TS_W]), 64'd0);
        chk("post_rst_count", 64'(bus.count_o), 64'd1);

        // Randomized traffic with bursty backpressure.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                   (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            step();
        end

        // Timestamp wrap: pushes at the last and first counter values.
        do_reset();
        set_in(1'b0, 1'b0, 1'b0);
        repeat ((1 << TS_W) - 1) step();
        set_in(1'b1, 1'b1, 1'b0);
        step();
        set_in(1'b1, 1'b1, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        chk("wrap_first_ts", 64'(bus.event_o[EW-1 -: TS_W]), 64'hFFFF);
        set_in(1'b0, 1'b0, 1'b1);
        step();
        chk("wrap_second_ts", 64'(bus.event_o[EW-1 -: TS_W]), 64'h0000);
        step();
        chk("wrap_empty", 64'(bus.count_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
